sparc_exu_ccrwr_arb: RTL and testbench



---
 rtl/sparc_exu_ccrwr_arb_pkg.sv | 28 ++
 rtl/sparc_exu_ccrwr_arb_hold.sv | 84 ++++++++
 rtl/sparc_exu_ccrwr_arb.sv | 144 ++++++++++++++
 tb/tb_sparc_exu_ccrwr_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_exu_ccrwr_arb_pkg.sv
// ----------------------------------------------------------------------------
// sparc_exu_ccrwr_arb_pkg
// Shared constants, types and helpers for the late CCR write arbiter.
//   NSRC        number of late-CC write sources (DIV, MUL, TLU)
//   SRC_*       source encodings, also the round-robin pointer values
//   CC_W        CCR data width {xcc, icc}
//   STARVE_MAX  starve count at which an entry ignores W-stage busy
// ----------------------------------------------------------------------------
package sparc_exu_ccrwr_arb_pkg;

    localparam int         NSRC       = 3;
    localparam logic [1:0] SRC_DIV    = 2'd0;
    localparam logic [1:0] SRC_MUL    = 2'd1;
    localparam logic [1:0] SRC_TLU    = 2'd2;
    localparam int         CC_W       = 8;
    localparam logic [1:0] STARVE_MAX = 2'd3;

    typedef struct packed {
        logic [1:0]      thr;
        logic [CC_W-1:0] cc;
    } ccr_wr_t;

    // Round-robin successor: DIV -> MUL -> TLU -> DIV.
    function automatic logic [1:0] rr_next(input logic [1:0] src);
        return (src == SRC_TLU) ? SRC_DIV : src + 2'd1;
    endfunction

endpackage

// File: rtl/sparc_exu_ccrwr_arb_hold.sv
// ----------------------------------------------------------------------------
// sparc_exu_ccrwr_hold
// One-entry hold buffer for a single late-CC write source, with accept
// handshake, per-thread kill and a saturating starve counter.
//   clk, arst_l      clock, asynchronous active-low reset
//   req_i/thr_i/cc_i incoming write request
//   wbusy_i          one-hot thread taking a W-stage CCR write in the slot
//   kill_i           per-thread discard of the pending entry
//   issue_i          this entry won arbitration this cycle
//   ack_o            accept pulse (combinational)
//   elig_o           entry may be granted this cycle
//   wr_o             held thread/data
// ----------------------------------------------------------------------------
module sparc_exu_ccrwr_hold
    import sparc_exu_ccrwr_arb_pkg::*;
(
    input  logic            clk,
    input  logic            arst_l,
    input  logic            req_i,
    input  logic [1:0]      thr_i,
    input  logic [CC_W-1:0] cc_i,
    input  logic [3:0]      wbusy_i,
    input  logic [3:0]      kill_i,
    input  logic            issue_i,
    output logic            ack_o,
    output logic            elig_o,
    output ccr_wr_t         wr_o
);

    logic       valid_q, valid_d;
    ccr_wr_t    wr_q, wr_d;
    logic [1:0] starve_q, starve_d;

    logic kill_hit;
    logic wb_blk;
    logic starved;
    logic cap;

    assign kill_hit = valid_q & kill_i[wr_q.thr];
    assign wb_blk   = wbusy_i[wr_q.thr];
    assign starved  = (starve_q == STARVE_MAX);

    // A killed entry is never granted; a starved one overrides W-stage busy.
    assign elig_o = valid_q & ~kill_hit & (~wb_blk | starved);

    // The slot frees up this edge if it is empty, issuing, or being killed.
    // Reset gates the ack so nothing is accepted while arst_l is low.
    assign ack_o = arst_l & req_i & (~valid_q | issue_i | kill_hit);

    // Requests for a thread being killed are acked but dropped.
    assign cap = ack_o & ~kill_i[thr_i];

    always_comb begin
        valid_d  = valid_q;
        wr_d     = wr_q;
        starve_d = starve_q;
        if (cap) begin
            valid_d  = 1'b1;
            wr_d.thr = thr_i;
            wr_d.cc  = cc_i;
            starve_d = 2'd0;
        end else if (issue_i || kill_hit) begin
            valid_d  = 1'b0;
            starve_d = 2'd0;
        end else if (valid_q && wb_blk && !starved) begin
            starve_d = starve_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            valid_q  <= 1'b0;
            wr_q     <= '0;
            starve_q <= 2'd0;
        end else begin
            valid_q  <= valid_d;
            wr_q     <= wr_d;
            starve_q <= starve_d;
        end
    end

    assign wr_o = wr_q;

endmodule

// File: rtl/sparc_exu_ccrwr_arb.sv
// ----------------------------------------------------------------------------
// sparc_exu_ccrwr_arb
// Arbitrates late CCR writes from the divider, multiplier and TLU into a
// single registered CCR write slot.  Each source owns a one-entry hold
// buffer; a round-robin pointer picks one eligible entry per cycle.
//   clk, arst_l                    clock, asynchronous active-low reset
//   se                             scan enable (no functional effect)
//   {div,mul,tlu}_ccr_{req,thr,cc} source write requests
//   ecl_ccr_wbusy_thr              thread with a W-stage CCR write in slot
//   tlu_exu_ccr_kill_thr           per-thread discard of pending writes
//   arb_{div,mul,tlu}_ack          one-cycle accept pulses
//   wb_ccr_setcc_g/thr_g           registered write slot valid/thread
//   divcntl_ccr_cc_g               registered write slot data
// ----------------------------------------------------------------------------
module sparc_exu_ccrwr_arb
    import sparc_exu_ccrwr_arb_pkg::*;
(
    input  logic            clk,
    input  logic            arst_l,
    input  logic            se,
    input  logic            div_ccr_req,
    input  logic [1:0]      div_ccr_thr,
    input  logic [CC_W-1:0] div_ccr_cc,
    input  logic            mul_ccr_req,
    input  logic [1:0]      mul_ccr_thr,
    input  logic [CC_W-1:0] mul_ccr_cc,
    input  logic            tlu_ccr_req,
    input  logic [1:0]      tlu_ccr_thr,
    input  logic [CC_W-1:0] tlu_ccr_cc,
    input  logic [3:0]      ecl_ccr_wbusy_thr,
    input  logic [3:0]      tlu_exu_ccr_kill_thr,
    output logic            arb_div_ack,
    output logic            arb_mul_ack,
    output logic            arb_tlu_ack,
    output logic            wb_ccr_setcc_g,
    output logic [1:0]      wb_ccr_thr_g,
    output logic [CC_W-1:0] divcntl_ccr_cc_g
);

    logic            unused_se;
    assign unused_se = se;

    logic [NSRC-1:0] src_req;
    logic [1:0]      src_thr [NSRC];
    logic [CC_W-1:0] src_cc  [NSRC];
    logic [NSRC-1:0] src_ack;
    logic [NSRC-1:0] src_elig;
    logic [NSRC-1:0] src_issue;
    ccr_wr_t         src_wr  [NSRC];

    assign src_req[SRC_DIV] = div_ccr_req;
    assign src_req[SRC_MUL] = mul_ccr_req;
    assign src_req[SRC_TLU] = tlu_ccr_req;
    assign src_thr[SRC_DIV] = div_ccr_thr;
    assign src_thr[SRC_MUL] = mul_ccr_thr;
    assign src_thr[SRC_TLU] = tlu_ccr_thr;
    assign src_cc[SRC_DIV]  = div_ccr_cc;
    assign src_cc[SRC_MUL]  = mul_ccr_cc;
    assign src_cc[SRC_TLU]  = tlu_ccr_cc;

    for (genvar g = 0; g < NSRC; g++) begin : g_hold
        sparc_exu_ccrwr_hold u_hold (
            .clk     (clk),
            .arst_l  (arst_l),
            .req_i   (src_req[g]),
            .thr_i   (src_thr[g]),
            .cc_i    (src_cc[g]),
            .wbusy_i (ecl_ccr_wbusy_thr),
            .kill_i  (tlu_exu_ccr_kill_thr),
            .issue_i (src_issue[g]),
            .ack_o   (src_ack[g]),
            .elig_o  (src_elig[g]),
            .wr_o    (src_wr[g])
        );
    end

    assign arb_div_ack = src_ack[SRC_DIV];
    assign arb_mul_ack = src_ack[SRC_MUL];
    assign arb_tlu_ack = src_ack[SRC_TLU];

    logic [1:0] ptr_q, ptr_d;
    logic       grant_vld;
    logic [1:0] grant_src;
    logic [1:0] cand;
    ccr_wr_t    grant_wr;

    // Scan eligible entries starting at the pointer; first hit wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < NSRC; k++) begin
            if (!grant_vld && src_elig[cand]) begin
                grant_vld = 1'b1;
                grant_src = cand;
            end
            cand = rr_next(cand);
        end
    end

    always_comb begin
        src_issue = '0;
        if (grant_vld) begin
            src_issue = 3'b001 << grant_src;
        end
    end

    always_comb begin
        case (grant_src)
            SRC_MUL: grant_wr = src_wr[SRC_MUL];
            SRC_TLU: grant_wr = src_wr[SRC_TLU];
            default: grant_wr = src_wr[SRC_DIV];
        endcase
    end

    assign ptr_d = grant_vld ? rr_next(grant_src) : ptr_q;

    logic            setcc_q;
    logic [1:0]      thr_q, thr_d;
    logic [CC_W-1:0] cc_q, cc_d;

    // Slot thread/data hold their last value on idle cycles.
    assign thr_d = grant_vld ? grant_wr.thr : thr_q;
    assign cc_d  = grant_vld ? grant_wr.cc  : cc_q;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ptr_q   <= SRC_DIV;
            setcc_q <= 1'b0;
            thr_q   <= 2'd0;
            cc_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            setcc_q <= grant_vld;
            thr_q   <= thr_d;
            cc_q    <= cc_d;
        end
    end

    assign wb_ccr_setcc_g   = setcc_q;
    assign wb_ccr_thr_g     = thr_q;
    assign divcntl_ccr_cc_g = cc_q;

endmodule

// File: tb/tb_sparc_exu_ccrwr_arb.sv
module tb_sparc_exu_ccrwr_arb;

    logic       clk = 1'b0;
    logic       arst_l = 1'b0;
    logic       se = 1'b0;
    logic       req_a [3];
    logic [1:0] thr_a [3];
    logic [7:0] cc_a  [3];
    logic [3:0] wbusy = 4'd0;
    logic [3:0] kill  = 4'd0;
    logic       arb_div_ack, arb_mul_ack, arb_tlu_ack;
    logic       wb_ccr_setcc_g;
    logic [1:0] wb_ccr_thr_g;
    logic [7:0] divcntl_ccr_cc_g;

    always #5 clk = ~clk;

    sparc_exu_ccrwr_arb dut (
        .clk                  (clk),
        .arst_l               (arst_l),
        .se                   (se),
        .div_ccr_req          (req_a[0]),
        .div_ccr_thr          (thr_a[0]),
        .div_ccr_cc           (cc_a[0]),
        .mul_ccr_req          (req_a[1]),
        .mul_ccr_thr          (thr_a[1]),
        .mul_ccr_cc           (cc_a[1]),
        .tlu_ccr_req          (req_a[2]),
        .tlu_ccr_thr          (thr_a[2]),
        .tlu_ccr_cc           (cc_a[2]),
        .ecl_ccr_wbusy_thr    (wbusy),
        .tlu_exu_ccr_kill_thr (kill),
        .arb_div_ack          (arb_div_ack),
        .arb_mul_ack          (arb_mul_ack),
        .arb_tlu_ack          (arb_tlu_ack),
        .wb_ccr_setcc_g       (wb_ccr_setcc_g),
        .wb_ccr_thr_g         (wb_ccr_thr_g),
        .divcntl_ccr_cc_g     (divcntl_ccr_cc_g)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per source a pending write (or none) with a count of
    // cycles it has waited behind a W-stage write; next source in line to win.
    bit pend   [3];
    int p_thr  [3];
    int p_cc   [3];
    int waited [3];
    int next_src;
    bit slot_v;
    int slot_thr, slot_cc;

    function automatic void model_reset();
        for (int s = 0; s < 3; s++) begin
            pend[s] = 0; p_thr[s] = 0; p_cc[s] = 0; waited[s] = 0;
        end
        next_src = 0; slot_v = 0; slot_thr = 0; slot_cc = 0;
    endfunction

    function automatic logic [1:0] dut_ack(input int s);
        case (s)
            0:       return {1'b0, arb_div_ack};
            1:       return {1'b0, arb_mul_ack};
            default: return {1'b0, arb_tlu_ack};
        endcase
    endfunction

    task automatic set_req(input int s, input int thr, input int cc);
        req_a[s] = 1'b1;
        thr_a[s] = 2'(thr);
        cc_a[s]  = 8'(cc);
    endtask

    // One clock cycle: predict and check at negedge, advance model at posedge,
    // then retire acked requests a little after the edge.
    task automatic cycle();
        bit can_go [3];
        bit acc    [3];
        int winner;
        @(negedge clk);
        for (int s = 0; s < 3; s++)
            can_go[s] = pend[s] && !kill[p_thr[s]] && (!wbusy[p_thr[s]] || waited[s] >= 3);
        winner = -1;
        for (int k = 0; k < 3; k++)
            if (winner < 0 && can_go[(next_src + k) % 3]) winner = (next_src + k) % 3;
        for (int s = 0; s < 3; s++)
            acc[s] = req_a[s] && (!pend[s] || winner == s || kill[p_thr[s]]);
        for (int s = 0; s < 3; s++)
            check_val($sformatf("ack%0d", s), 32'(dut_ack(s)), 32'(acc[s]));
        check_val("setcc", 32'(wb_ccr_setcc_g), 32'(slot_v));
        check_val("thr_g", 32'(wb_ccr_thr_g), 32'(slot_thr));
        check_val("cc_g", 32'(divcntl_ccr_cc_g), 32'(slot_cc));
        @(posedge clk);
        slot_v = (winner >= 0);
        if (winner >= 0) begin
            slot_thr = p_thr[winner];
            slot_cc  = p_cc[winner];
            next_src = (winner + 1) % 3;
        end
        for (int s = 0; s < 3; s++) begin
            if (acc[s] && !kill[thr_a[s]]) begin
                pend[s] = 1; p_thr[s] = thr_a[s]; p_cc[s] = cc_a[s]; waited[s] = 0;
            end else if (winner == s || (pend[s] && kill[p_thr[s]])) begin
                pend[s] = 0; waited[s] = 0;
            end else if (pend[s] && wbusy[p_thr[s]] && waited[s] < 3) begin
                waited[s]++;
            end
        end
        #1;
        for (int s = 0; s < 3; s++) if (acc[s]) req_a[s] = 1'b0;
    endtask

    task automatic reset_pulse();
        arst_l = 1'b0;
        #1;
        check_val("rst_setcc", 32'(wb_ccr_setcc_g), 32'd0);
        check_val("rst_thr", 32'(wb_ccr_thr_g), 32'd0);
        check_val("rst_cc", 32'(divcntl_ccr_cc_g), 32'd0);
        check_val("rst_acks", {29'd0, arb_div_ack, arb_mul_ack, arb_tlu_ack}, 32'd0);
        for (int s = 0; s < 3; s++) req_a[s] = 1'b0;
        wbusy = 4'd0;
        kill  = 4'd0;
        @(posedge clk);
        #1;
        arst_l = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            req_a[s] = 1'b0; thr_a[s] = 2'd0; cc_a[s] = 8'd0;
        end
        model_reset();
        set_req(0, 1, 8'h11);
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();
        for (int i = 0; i < 3; i++) cycle();

        // Single DIV write, exact two-cycle latency.
        set_req(0, 2, 8'h5A);
        cycle();
        cycle();
        check_val("lat_setcc", 32'(wb_ccr_setcc_g), 32'd1);
        check_val("lat_thr", 32'(wb_ccr_thr_g), 32'd2);
        check_val("lat_cc", 32'(divcntl_ccr_cc_g), 32'h5A);
        for (int i = 0; i < 3; i++) cycle();

        // All three sources at once, twice.
        for (int rep = 0; rep < 2; rep++) begin
            set_req(0, 0, 8'hD0 + rep);
            set_req(1, 1, 8'hE0 + rep);
            set_req(2, 3, 8'hF0 + rep);
            for (int i = 0; i < 5; i++) cycle();
        end

        // MUL thread 1 held off by a continuous W-stage write.
        wbusy = 4'b0010;
        set_req(1, 1, 8'h3C);
        for (int i = 0; i < 4; i++) cycle();
        check_val("starve_wait", 32'(wb_ccr_setcc_g), 32'd0);
        cycle();
        check_val("starve_issue", 32'(wb_ccr_setcc_g), 32'd1);
        check_val("starve_cc", 32'(divcntl_ccr_cc_g), 32'h3C);
        cycle();
        wbusy = 4'd0;
        cycle();

        // TLU thread 3 killed while pending, plus same-cycle request killed.
        wbusy = 4'b1000;
        set_req(2, 3, 8'h77);
        cycle();
        cycle();
        kill = 4'b1000;
        set_req(2, 3, 8'h78);
        cycle();
        kill  = 4'd0;
        wbusy = 4'd0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_val("kill_noslot", 32'(wb_ccr_setcc_g), 32'd0);
        end

        // DIV hold full and blocked; second request waits for the issue.
        wbusy = 4'b0100;
        set_req(0, 2, 8'hA1);
        cycle();
        set_req(0, 2, 8'hA2);
        for (int i = 0; i < 8; i++) cycle();
        wbusy = 4'd0;
        for (int i = 0; i < 3; i++) cycle();

        // Reset with all three holds full.
        wbusy = 4'b0001;
        set_req(0, 0, 8'h01);
        set_req(1, 0, 8'h02);
        set_req(2, 0, 8'h03);
        cycle();
        reset_pulse();
        for (int i = 0; i < 5; i++) cycle();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            for (int s = 0; s < 3; s++)
                if (!req_a[s] && $urandom_range(2) == 0)
                    set_req(s, int'($urandom_range(3)), int'($urandom_range(255)));
            wbusy = ($urandom_range(1) == 0) ? 4'd0 : (4'b0001 << $urandom_range(3));
            kill  = ($urandom_range(15) == 0) ? (4'b0001 << $urandom_range(3)) : 4'd0;
            if ($urandom_range(499) == 0) reset_pulse();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
